mem_wb_stage: RTL and testbench

- Consumer end of the ALU result interface: accepts one registered ALU result per handshake and performs the memory access for loads/stores.
- Memory access goes through a valid/ready request port to the data cache. Load responses are formatted before writeback.
- Drives the register-file write port; non-memory results pass straight to writeback.
- Sits between the ALU stage and the register file; back-pressures the ALU via in_ready.

---
 rtl/mem_wb_stage.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: takes ALU results, issues data-cache requests for loads and stores, and drives the register-file write port.
// Optional build macro MEM_MISALIGN_TRAP_EN adds misalign_trap and suppresses misaligned accesses.
module mem_wb_stage #(
    parameter int XLEN = 64,
    parameter int PCW  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] data_in,
    input  logic [4:0]      reg_dest_in,
    input  logic            wr_en_in,
    input  logic [XLEN-1:0] mem_addr_in,
    input  logic            is_load_in,
    input  logic            is_store_in,
    input  logic [1:0]      mem_size_in,
    input  logic            load_unsigned_in,
    input  logic            is_ecall_in,
    input  logic [PCW-1:0]  pc_in,
    output logic            dc_req_valid,
    input  logic            dc_req_ready,
    output logic            dc_req_write,
    output logic [XLEN-1:0] dc_req_addr,
    output logic [XLEN-1:0] dc_req_wdata,
    output logic [7:0]      dc_req_strb,
    input  logic            dc_resp_valid,
    input  logic [XLEN-1:0] dc_resp_data,
    output logic            rf_wr_en,
    output logic [4:0]      rf_wr_addr,
    output logic [XLEN-1:0] rf_wr_data,
    output logic [PCW-1:0]  wb_pc,
    output logic            wb_ecall
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic            misalign_trap
`endif
);

    typedef enum logic [1:0] {IDLE, REQ_ST, REQ_LD, WAIT_LD} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] req_wdata_q, req_wdata_d;
    logic [7:0]      req_strb_q, req_strb_d;
    logic [2:0]      off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [4:0]      rd_q, rd_d;
    logic [PCW-1:0]  pc_q, pc_d;
    logic            ecall_q, ecall_d;
    logic            rf_wr_en_q, rf_wr_en_d;
    logic [4:0]      rf_wr_addr_q, rf_wr_addr_d;
    logic [XLEN-1:0] rf_wr_data_q, rf_wr_data_d;
    logic [PCW-1:0]  wb_pc_q, wb_pc_d;
    logic            wb_ecall_q, wb_ecall_d;
    logic            trap_q, trap_d;
    logic            load_done;
    logic [7:0]      strb_base;

    function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] raw, input logic [2:0] off,
                                                 input logic [1:0] size, input logic uns);
        logic [XLEN-1:0] s;
        s = raw >> {off, 3'b000};
        case (size)
            2'd0:    return {{(XLEN-8){s[7] & ~uns}}, s[7:0]};
            2'd1:    return {{(XLEN-16){s[15] & ~uns}}, s[15:0]};
            2'd2:    return {{(XLEN-32){s[31] & ~uns}}, s[31:0]};
            default: return s;
        endcase
    endfunction

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    always_comb begin
        case (mem_size_in)
            2'd1:    misaligned = mem_addr_in[0];
            2'd2:    misaligned = (mem_addr_in[1:0] != 2'd0);
            2'd3:    misaligned = (mem_addr_in[2:0] != 3'd0);
            default: misaligned = 1'b0;
        endcase
    end
`endif

    always_comb begin
        case (mem_size_in)
            2'd0:    strb_base = 8'h01;
            2'd1:    strb_base = 8'h03;
            2'd2:    strb_base = 8'h0F;
            default: strb_base = 8'hFF;
        endcase
    end

    // A response arriving with the request handshake completes the load immediately
    assign load_done = ((state_q == REQ_LD) && dc_req_ready && dc_resp_valid) ||
                       ((state_q == WAIT_LD) && dc_resp_valid);

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_strb_d   = req_strb_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        rd_d         = rd_q;
        pc_d         = pc_q;
        ecall_d      = ecall_q;
        rf_wr_en_d   = 1'b0;
        rf_wr_addr_d = rf_wr_addr_q;
        rf_wr_data_d = rf_wr_data_q;
        wb_pc_d      = wb_pc_q;
        wb_ecall_d   = 1'b0;
        trap_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!(is_load_in || is_store_in)) begin
                        rf_wr_en_d   = wr_en_in && (reg_dest_in != 5'd0);
                        rf_wr_addr_d = reg_dest_in;
                        rf_wr_data_d = data_in;
                        wb_pc_d      = pc_in;
                        wb_ecall_d   = is_ecall_in;
                    end
`ifdef MEM_MISALIGN_TRAP_EN
                    else if (misaligned) begin
                        trap_d  = 1'b1;
                        wb_pc_d = pc_in;
                    end
`endif
                    else begin
                        req_addr_d  = {mem_addr_in[XLEN-1:3], 3'b000};
                        req_wdata_d = data_in << {mem_addr_in[2:0], 3'b000};
                        req_strb_d  = strb_base << mem_addr_in[2:0];
                        off_d       = mem_addr_in[2:0];
                        size_d      = mem_size_in;
                        uns_d       = load_unsigned_in;
                        rd_d        = reg_dest_in;
                        pc_d        = pc_in;
                        ecall_d     = is_ecall_in;
                        state_d     = is_store_in ? REQ_ST : REQ_LD;
                    end
                end
            end
            REQ_ST: begin
                if (dc_req_ready) begin
                    state_d    = IDLE;
                    wb_pc_d    = pc_q;
                    wb_ecall_d = ecall_q;
                end
            end
            REQ_LD: begin
                if (dc_req_ready) state_d = WAIT_LD;
            end
            default: ;
        endcase
        if (load_done) begin
            state_d      = IDLE;
            rf_wr_en_d   = (rd_q != 5'd0);
            rf_wr_addr_d = rd_q;
            rf_wr_data_d = fmt_load(dc_resp_data, off_q, size_q, uns_q);
            wb_pc_d      = pc_q;
            wb_ecall_d   = ecall_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_strb_q   <= '0;
            off_q        <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            rd_q         <= '0;
            pc_q         <= '0;
            ecall_q      <= 1'b0;
            rf_wr_en_q   <= 1'b0;
            rf_wr_addr_q <= '0;
            rf_wr_data_q <= '0;
            wb_pc_q      <= '0;
            wb_ecall_q   <= 1'b0;
            trap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_strb_q   <= req_strb_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            rd_q         <= rd_d;
            pc_q         <= pc_d;
            ecall_q      <= ecall_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_wr_addr_q <= rf_wr_addr_d;
            rf_wr_data_q <= rf_wr_data_d;
            wb_pc_q      <= wb_pc_d;
            wb_ecall_q   <= wb_ecall_d;
            trap_q       <= trap_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign dc_req_valid = (state_q == REQ_ST) || (state_q == REQ_LD);
    assign dc_req_write = (state_q == REQ_ST);
    assign dc_req_addr  = req_addr_q;
    assign dc_req_wdata = req_wdata_q;
    assign dc_req_strb  = req_strb_q;
    assign rf_wr_en     = rf_wr_en_q;
    assign rf_wr_addr   = rf_wr_addr_q;
    assign rf_wr_data   = rf_wr_data_q;
    assign wb_pc        = wb_pc_q;
    assign wb_ecall     = wb_ecall_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign_trap = trap_q;
`else
    logic unused_trap;
    assign unused_trap = trap_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized self-checking bench for mem_wb_stage; expected values come from byte-level reference functions.
module tb_mem_wb_stage;
    localparam int XLEN = 64;
    localparam int PCW  = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0, in_ready;
    logic [XLEN-1:0] data_in = '0;
    logic [4:0]      reg_dest_in = '0;
    logic            wr_en_in = 1'b0;
    logic [XLEN-1:0] mem_addr_in = '0;
    logic            is_load_in = 1'b0, is_store_in = 1'b0;
    logic [1:0]      mem_size_in = '0;
    logic            load_unsigned_in = 1'b0, is_ecall_in = 1'b0;
    logic [PCW-1:0]  pc_in = '0;
    logic            dc_req_valid, dc_req_ready = 1'b0, dc_req_write;
    logic [XLEN-1:0] dc_req_addr, dc_req_wdata;
    logic [7:0]      dc_req_strb;
    logic            dc_resp_valid = 1'b0;
    logic [XLEN-1:0] dc_resp_data = '0;
    logic            rf_wr_en;
    logic [4:0]      rf_wr_addr;
    logic [XLEN-1:0] rf_wr_data;
    logic [PCW-1:0]  wb_pc;
    logic            wb_ecall;
`ifdef MEM_MISALIGN_TRAP_EN
    logic            misalign_trap;
`endif

    int checks = 0;
    int errors = 0;

    mem_wb_stage #(.XLEN(XLEN), .PCW(PCW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .reg_dest_in(reg_dest_in), .wr_en_in(wr_en_in), .mem_addr_in(mem_addr_in),
        .is_load_in(is_load_in), .is_store_in(is_store_in), .mem_size_in(mem_size_in),
        .load_unsigned_in(load_unsigned_in), .is_ecall_in(is_ecall_in), .pc_in(pc_in),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_write(dc_req_write),
        .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata), .dc_req_strb(dc_req_strb),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .rf_wr_en(rf_wr_en),
        .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .wb_pc(wb_pc), .wb_ecall(wb_ecall)
`ifdef MEM_MISALIGN_TRAP_EN
        , .misalign_trap(misalign_trap)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return 1 << size;
    endfunction

    function automatic logic [7:0] ref_strb(input logic [2:0] o, input logic [1:0] size);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = (b >= int'(o)) && (b < int'(o) + nbytes(size));
        return r;
    endfunction

    function automatic logic [63:0] ref_wdata(input logic [63:0] d, input logic [2:0] o);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) if (b >= int'(o)) r[8*b +: 8] = d[8*(b-int'(o)) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] ref_load(input logic [63:0] resp, input logic [2:0] o,
                                             input logic [1:0] size, input logic uns);
        logic [63:0] r;
        int n;
        n = nbytes(size);
        r = '0;
        for (int i = 0; i < n; i++) if (int'(o) + i < 8) r[8*i +: 8] = resp[8*(int'(o)+i) +: 8];
        if (!uns && n < 8 && r[8*n-1]) for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
        return r;
    endfunction

    function automatic logic [63:0] rand_addr(input logic [1:0] size);
        logic [63:0] a;
        a = {$urandom, $urandom};
`ifdef MEM_MISALIGN_TRAP_EN
        a = a & ~(64'(nbytes(size)) - 64'd1);
`else
        if (size == 2'd3) a = a; // misaligned lanes are allowed to truncate here
`endif
        return a;
    endfunction

    task automatic clear_inputs;
        in_valid = 1'b0; is_load_in = 1'b0; is_store_in = 1'b0; is_ecall_in = 1'b0;
        wr_en_in = 1'b0; data_in = {$urandom, $urandom}; mem_addr_in = {$urandom, $urandom};
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick; tick;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        checks++; if (dc_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %0b expected 0", dc_req_valid); end
        checks++; if (rf_wr_en !== 1'b0 || rf_wr_data !== '0 || rf_wr_addr !== '0) begin errors++; $display("FAIL reset_rf: got en=%0b a=%0d d=%h expected 0", rf_wr_en, rf_wr_addr, rf_wr_data); end
        checks++; if (wb_pc !== '0 || wb_ecall !== 1'b0) begin errors++; $display("FAIL reset_wb: got pc=%h ecall=%0b expected 0", wb_pc, wb_ecall); end
        checks++; if (dc_req_addr !== '0 || dc_req_strb !== '0 || dc_req_write !== 1'b0) begin errors++; $display("FAIL reset_req_fields: got a=%h s=%h w=%0b expected 0", dc_req_addr, dc_req_strb, dc_req_write); end
`ifdef MEM_MISALIGN_TRAP_EN
        checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL reset_trap: got %0b expected 0", misalign_trap); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_alu_ops;
        logic [63:0] d; logic [4:0] rd; logic we, ec; logic [31:0] pc;
        for (int i = 0; i < 20; i++) begin
            d  = (i == 0) ? 64'h2A : {$urandom, $urandom};
            rd = (i == 0) ? 5'd5 : 5'($urandom_range(0, 31));
            we = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ec = (i == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
            pc = $urandom;
            in_valid = 1'b1; is_load_in = 1'b0; is_store_in = 1'b0; data_in = d; reg_dest_in = rd;
            wr_en_in = we; is_ecall_in = ec; pc_in = pc; mem_addr_in = {$urandom, $urandom};
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL alu_in_ready: got %0b expected 1", in_ready); end
            tick;
            checks++; if (rf_wr_en !== (we && rd != 0)) begin errors++; $display("FAIL alu_wr_en: got %0b expected %0b", rf_wr_en, we && rd != 0); end
            if (we && rd != 0) begin
                checks++; if (rf_wr_addr !== rd || rf_wr_data !== d) begin errors++; $display("FAIL alu_wr: got a=%0d d=%h expected a=%0d d=%h", rf_wr_addr, rf_wr_data, rd, d); end
            end
            checks++; if (wb_pc !== pc || wb_ecall !== ec) begin errors++; $display("FAIL alu_retire: got pc=%h ec=%0b expected pc=%h ec=%0b", wb_pc, wb_ecall, pc, ec); end
        end
        clear_inputs;
        tick;
        checks++; if (rf_wr_en !== 1'b0 || wb_ecall !== 1'b0 || wb_pc !== pc) begin errors++; $display("FAIL alu_idle_hold: got en=%0b ec=%0b pc=%h expected 0 0 %h", rf_wr_en, wb_ecall, wb_pc, pc); end
    endtask

    task automatic do_store(input logic [63:0] addr, input logic [63:0] d, input logic [1:0] size,
                            input int delay);
        logic [31:0] pc;
        pc = $urandom;
        in_valid = 1'b1; is_store_in = 1'b1; is_load_in = 1'($urandom_range(0, 1)); data_in = d;
        mem_addr_in = addr; mem_size_in = size; pc_in = pc; wr_en_in = 1'b0; is_ecall_in = 1'b0;
        reg_dest_in = 5'($urandom_range(1, 31));
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL st_accept: got %0b expected 1", in_ready); end
        tick;
        clear_inputs;
        for (int k = 0; k <= delay; k++) begin
            dc_req_ready = (k == delay);
            dc_resp_valid = 1'($urandom_range(0, 1));
            checks++; if (dc_req_valid !== 1'b1 || dc_req_write !== 1'b1 || in_ready !== 1'b0 || rf_wr_en !== 1'b0) begin errors++; $display("FAIL st_ctrl: got v=%0b w=%0b rdy=%0b en=%0b expected 1 1 0 0", dc_req_valid, dc_req_write, in_ready, rf_wr_en); end
            checks++; if (dc_req_addr !== {addr[63:3], 3'b000} || dc_req_strb !== ref_strb(addr[2:0], size) || dc_req_wdata !== ref_wdata(d, addr[2:0])) begin errors++; $display("FAIL st_fields: got a=%h s=%h w=%h expected a=%h s=%h w=%h", dc_req_addr, dc_req_strb, dc_req_wdata, {addr[63:3], 3'b000}, ref_strb(addr[2:0], size), ref_wdata(d, addr[2:0])); end
            tick;
        end
        dc_req_ready = 1'b0; dc_resp_valid = 1'b0;
        checks++; if (dc_req_valid !== 1'b0 || in_ready !== 1'b1 || rf_wr_en !== 1'b0) begin errors++; $display("FAIL st_done: got v=%0b rdy=%0b en=%0b expected 0 1 0", dc_req_valid, in_ready, rf_wr_en); end
        checks++; if (wb_pc !== pc || wb_ecall !== 1'b0) begin errors++; $display("FAIL st_retire: got pc=%h ec=%0b expected %h 0", wb_pc, wb_ecall, pc); end
    endtask

    task automatic do_load(input logic [63:0] addr, input logic [1:0] size, input logic uns,
                           input logic [4:0] rd, input logic [63:0] resp, input int req_delay,
                           input logic same, input int resp_delay);
        logic [31:0] pc;
        logic [63:0] exp;
        pc = $urandom;
        exp = ref_load(resp, addr[2:0], size, uns);
        in_valid = 1'b1; is_load_in = 1'b1; is_store_in = 1'b0; mem_addr_in = addr; mem_size_in = size;
        load_unsigned_in = uns; reg_dest_in = rd; wr_en_in = 1'b1; pc_in = pc; is_ecall_in = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ld_accept: got %0b expected 1", in_ready); end
        tick;
        clear_inputs;
        for (int k = 0; k <= req_delay; k++) begin
            dc_req_ready = (k == req_delay);
            if (k == req_delay && same) begin dc_resp_valid = 1'b1; dc_resp_data = resp; end
            checks++; if (dc_req_valid !== 1'b1 || dc_req_write !== 1'b0 || in_ready !== 1'b0 || rf_wr_en !== 1'b0) begin errors++; $display("FAIL ld_req_ctrl: got v=%0b w=%0b rdy=%0b en=%0b expected 1 0 0 0", dc_req_valid, dc_req_write, in_ready, rf_wr_en); end
            checks++; if (dc_req_addr !== {addr[63:3], 3'b000}) begin errors++; $display("FAIL ld_req_addr: got %h expected %h", dc_req_addr, {addr[63:3], 3'b000}); end
            tick;
        end
        dc_req_ready = 1'b0; dc_resp_valid = 1'b0; dc_resp_data = {$urandom, $urandom};
        if (!same) begin
            for (int k = 0; k < resp_delay; k++) begin
                checks++; if (dc_req_valid !== 1'b0 || in_ready !== 1'b0 || rf_wr_en !== 1'b0) begin errors++; $display("FAIL ld_wait: got v=%0b rdy=%0b en=%0b expected 0 0 0", dc_req_valid, in_ready, rf_wr_en); end
                tick;
            end
            dc_resp_valid = 1'b1; dc_resp_data = resp;
            tick;
            dc_resp_valid = 1'b0; dc_resp_data = {$urandom, $urandom};
        end
        checks++; if (rf_wr_en !== (rd != 0)) begin errors++; $display("FAIL ld_wr_en: got %0b expected %0b", rf_wr_en, rd != 0); end
        if (rd != 0) begin
            checks++; if (rf_wr_data !== exp || rf_wr_addr !== rd) begin errors++; $display("FAIL ld_data: got a=%0d d=%h expected a=%0d d=%h", rf_wr_addr, rf_wr_data, rd, exp); end
        end
        checks++; if (wb_pc !== pc || in_ready !== 1'b1) begin errors++; $display("FAIL ld_retire: got pc=%h rdy=%0b expected %h 1", wb_pc, in_ready, pc); end
    endtask

    task automatic test_stores;
        logic [1:0] sz;
        do_store(64'h1003, 64'hAB, 2'd0, 3);
        for (int i = 0; i < 8; i++) begin
            sz = 2'($urandom_range(0, 3));
            do_store(rand_addr(sz), {$urandom, $urandom}, sz, $urandom_range(0, 3));
        end
    endtask

    task automatic test_loads;
        logic [1:0] sz;
        do_load(64'h2006, 2'd1, 1'b0, 5'd7, 64'h8001_0000_0000_0000, 1, 1'b0, 1);
        do_load(64'h2006, 2'd1, 1'b1, 5'd8, 64'h8001_0000_0000_0000, 0, 1'b1, 0);
        for (int i = 0; i < 12; i++) begin
            sz = 2'($urandom_range(0, 3));
            do_load(rand_addr(sz), sz, 1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)),
                    {$urandom, $urandom}, $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] d;
        do_load(64'h4000, 2'd3, 1'b0, 5'd0, {$urandom, $urandom}, 1, 1'b0, 2);
        d = {$urandom, $urandom};
        in_valid = 1'b1; data_in = d; reg_dest_in = 5'd9; wr_en_in = 1'b1; pc_in = 32'h1234;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %0b expected 1", in_ready); end
        tick;
        clear_inputs;
        checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd9 || rf_wr_data !== d) begin errors++; $display("FAIL b2b_wr: got en=%0b a=%0d d=%h expected 1 9 %h", rf_wr_en, rf_wr_addr, rf_wr_data, d); end
        dc_resp_valid = 1'b1;
        tick;
        dc_resp_valid = 1'b0;
        checks++; if (rf_wr_en !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL idle_resp_ignored: got en=%0b rdy=%0b expected 0 1", rf_wr_en, in_ready); end
    endtask

    task automatic test_reset_mid;
        in_valid = 1'b1; is_load_in = 1'b1; mem_addr_in = 64'h5008; mem_size_in = 2'd3;
        reg_dest_in = 5'd3; wr_en_in = 1'b1; pc_in = 32'hBEEF;
        tick;
        clear_inputs;
        dc_req_ready = 1'b1;
        tick;
        dc_req_ready = 1'b0;
        checks++; if (in_ready !== 1'b0 || dc_req_valid !== 1'b0) begin errors++; $display("FAIL mid_wait_state: got rdy=%0b v=%0b expected 0 0", in_ready, dc_req_valid); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1 || rf_wr_en !== 1'b0 || wb_pc !== '0 || rf_wr_data !== '0) begin errors++; $display("FAIL mid_reset_vals: got rdy=%0b en=%0b pc=%h d=%h expected 1 0 0 0", in_ready, rf_wr_en, wb_pc, rf_wr_data); end
        dc_resp_valid = 1'b1; dc_resp_data = 64'hDEAD_BEEF_0000_1111;
        tick;
        dc_resp_valid = 1'b0;
        tick;
        checks++; if (rf_wr_en !== 1'b0 || rf_wr_data !== '0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_stray_resp: got en=%0b d=%h rdy=%0b expected 0 0 1", rf_wr_en, rf_wr_data, in_ready); end
    endtask

    task automatic test_misalign;
`ifdef MEM_MISALIGN_TRAP_EN
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; is_store_in = (i == 0); is_load_in = (i != 0); mem_addr_in = 64'h3002;
            mem_size_in = 2'd2; data_in = 64'h1122_3344; reg_dest_in = 5'd4; wr_en_in = 1'b1;
            pc_in = 32'h3000 + 32'(i);
            tick;
            clear_inputs;
            checks++; if (misalign_trap !== 1'b1 || wb_pc !== 32'h3000 + 32'(i)) begin errors++; $display("FAIL trap_pulse: got t=%0b pc=%h expected 1 %h", misalign_trap, wb_pc, 32'h3000 + 32'(i)); end
            checks++; if (dc_req_valid !== 1'b0 || rf_wr_en !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL trap_noreq: got v=%0b en=%0b rdy=%0b expected 0 0 1", dc_req_valid, rf_wr_en, in_ready); end
            tick;
            checks++; if (misalign_trap !== 1'b0 || dc_req_valid !== 1'b0) begin errors++; $display("FAIL trap_one_cycle: got t=%0b v=%0b expected 0 0", misalign_trap, dc_req_valid); end
        end
`else
        do_store(64'h3002, 64'h1122_3344, 2'd2, 1);
        checks++; if (dc_req_strb !== 8'h3C) begin errors++; $display("FAIL sw_misalign_strb: got %h expected 3c", dc_req_strb); end
`endif
    endtask

    initial begin
        clear_inputs;
        test_reset;
        test_alu_ops;
        test_stores;
        test_loads;
        test_back_to_back;
        test_reset_mid;
        test_misalign;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
